// File: rtl/rv_pkg.sv
// Shared RV32I encodings for the execute stage: writeback selects, ALU and branch funct3 codes,
// and the bit positions inside BrOp.
package rv_pkg;

  localparam int unsigned REG_IDX_W = 5;

  localparam logic [1:0] RF_ALU = 2'b00;
  localparam logic [1:0] RF_MEM = 2'b01;
  localparam logic [1:0] RF_PC4 = 2'b10;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam int unsigned BROP_JUMP   = 4;
  localparam int unsigned BROP_BRANCH = 3;

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I integer ALU; immediate forms never subtract.
module rv_alu
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      funct3,
  input  logic            type_alu,
  input  logic            is_imm,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned SHAMT_W = 5;

  logic [SHAMT_W-1:0] shamt;
  assign shamt = op2[SHAMT_W-1:0];

  always_comb begin
    result_c = '0;
    case (funct3)
      F3_ADD:  result_c = (type_alu && !is_imm) ? (op1 - op2) : (op1 + op2);
      F3_SLL:  result_c = op1 << shamt;
      F3_SLT:  result_c = XLEN'($signed(op1) < $signed(op2));
      F3_SLTU: result_c = XLEN'(op1 < op2);
      F3_XOR:  result_c = op1 ^ op2;
      F3_SR:   result_c = type_alu ? XLEN'($signed(op1) >>> shamt) : (op1 >> shamt);
      F3_OR:   result_c = op1 | op2;
      F3_AND:  result_c = op1 & op2;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module ex_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      sum_out_in,
  input  logic [XLEN-1:0]      pc_out_in,
  input  logic [XLEN-1:0]      data1_in,
  input  logic [XLEN-1:0]      data2_in,
  input  logic [XLEN-1:0]      imm_in,
  input  logic [REG_IDX_W-1:0] rs1_in,
  input  logic [REG_IDX_W-1:0] rs2_in,
  input  logic [REG_IDX_W-1:0] rd_in,
  input  logic                 we_in,
  input  logic                 store_in,
  input  logic                 load_in,
  input  logic [1:0]           controlRF_in,
  input  logic                 controlALU_in,
  input  logic                 controlOp1_in,
  input  logic [2:0]           funct3_alu_in,
  input  logic                 Type_alu_in,
  input  logic [2:0]           Type_dm_in,
  input  logic [4:0]           BrOp_in,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 mem_stall,
  output logic [XLEN-1:0]      alu_q,
  output logic [XLEN-1:0]      store_data_q,
  output logic [XLEN-1:0]      pc4_q,
  output logic [REG_IDX_W-1:0] rd_q,
  output logic                 we_q,
  output logic                 store_q,
  output logic                 load_q,
  output logic [1:0]           controlRF_q,
  output logic [2:0]           Type_dm_q,
  output logic                 NextPCSrc,
  output logic [XLEN-1:0]      branch_target
);

  logic [XLEN-1:0] exmem_val_c, fwd_rs1_c, fwd_rs2_c, op1_c, op2_c, alu_res_c;
  logic            exmem_fwd_ok_c, br_cond_c;

  logic [XLEN-1:0]      alu_d, store_data_d, pc4_d;
  logic [REG_IDX_W-1:0] rd_d;
  logic                 we_d, store_d, load_d;
  logic [1:0]           controlRF_d;
  logic [2:0]           Type_dm_d;

  // Load data is not available yet in EX/MEM, so only ALU/PC+4 results forward from there.
  assign exmem_fwd_ok_c = we_q && !load_q && (controlRF_q != RF_MEM);
  assign exmem_val_c    = (controlRF_q == RF_PC4) ? pc4_q : alu_q;

  always_comb begin
    fwd_rs1_c = data1_in;
    if (rs1_in == '0)                            fwd_rs1_c = '0;
    else if (exmem_fwd_ok_c && (rd_q == rs1_in)) fwd_rs1_c = exmem_val_c;
    else if (wb_we && (wb_rd == rs1_in))         fwd_rs1_c = wb_data;
  end

  always_comb begin
    fwd_rs2_c = data2_in;
    if (rs2_in == '0)                            fwd_rs2_c = '0;
    else if (exmem_fwd_ok_c && (rd_q == rs2_in)) fwd_rs2_c = exmem_val_c;
    else if (wb_we && (wb_rd == rs2_in))         fwd_rs2_c = wb_data;
  end

  assign op1_c = controlOp1_in ? pc_out_in : fwd_rs1_c;
  assign op2_c = controlALU_in ? imm_in    : fwd_rs2_c;

  rv_alu #(.XLEN(XLEN)) u_alu (
    .op1      (op1_c),
    .op2      (op2_c),
    .funct3   (funct3_alu_in),
    .type_alu (Type_alu_in),
    .is_imm   (controlALU_in),
    .result_c (alu_res_c)
  );

  always_comb begin
    br_cond_c = 1'b0;
    case (BrOp_in[2:0])
      BR_EQ:   br_cond_c = (fwd_rs1_c == fwd_rs2_c);
      BR_NE:   br_cond_c = (fwd_rs1_c != fwd_rs2_c);
      BR_LT:   br_cond_c = ($signed(fwd_rs1_c) < $signed(fwd_rs2_c));
      BR_GE:   br_cond_c = ($signed(fwd_rs1_c) >= $signed(fwd_rs2_c));
      BR_LTU:  br_cond_c = (fwd_rs1_c < fwd_rs2_c);
      BR_GEU:  br_cond_c = (fwd_rs1_c >= fwd_rs2_c);
      default: br_cond_c = 1'b0;
    endcase
  end

  assign NextPCSrc     = rst && (BrOp_in[BROP_JUMP] || (BrOp_in[BROP_BRANCH] && br_cond_c));
  assign branch_target = {alu_res_c[XLEN-1:1], 1'b0};

  // EX/MEM next state: hold under mem_stall, otherwise capture the instruction in EX.
  always_comb begin
    alu_d        = alu_q;
    store_data_d = store_data_q;
    pc4_d        = pc4_q;
    rd_d         = rd_q;
    we_d         = we_q;
    store_d      = store_q;
    load_d       = load_q;
    controlRF_d  = controlRF_q;
    Type_dm_d    = Type_dm_q;
    if (!mem_stall) begin
      alu_d        = alu_res_c;
      store_data_d = fwd_rs2_c;
      pc4_d        = sum_out_in;
      rd_d         = rd_in;
      we_d         = we_in;
      store_d      = store_in;
      load_d       = load_in;
      controlRF_d  = controlRF_in;
      Type_dm_d    = Type_dm_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q        <= '0;
      store_data_q <= '0;
      pc4_q        <= XLEN'(RESET_PC);
      rd_q         <= '0;
      we_q         <= 1'b0;
      store_q      <= 1'b0;
      load_q       <= 1'b0;
      controlRF_q  <= '0;
      Type_dm_q    <= '0;
    end else begin
      alu_q        <= alu_d;
      store_data_q <= store_data_d;
      pc4_q        <= pc4_d;
      rd_q         <= rd_d;
      we_q         <= we_d;
      store_q      <= store_d;
      load_q       <= load_d;
      controlRF_q  <= controlRF_d;
      Type_dm_q    <= Type_dm_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk, rst;
  logic [31:0] sum_out_in, pc_out_in, data1_in, data2_in, imm_in, wb_data;
  logic [4:0]  rs1_in, rs2_in, rd_in, wb_rd, BrOp_in;
  logic        we_in, store_in, load_in, controlALU_in, controlOp1_in, Type_alu_in, wb_we, mem_stall;
  logic [1:0]  controlRF_in;
  logic [2:0]  funct3_alu_in, Type_dm_in;
  logic [31:0] alu_q, store_data_q, pc4_q, branch_target;
  logic [4:0]  rd_q;
  logic        we_q, store_q, load_q, NextPCSrc;
  logic [1:0]  controlRF_q;
  logic [2:0]  Type_dm_q;

  int n_vec = 0;
  int n_err = 0;

  ex_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .sum_out_in(sum_out_in), .pc_out_in(pc_out_in),
    .data1_in(data1_in), .data2_in(data2_in), .imm_in(imm_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .we_in(we_in), .store_in(store_in), .load_in(load_in),
    .controlRF_in(controlRF_in), .controlALU_in(controlALU_in), .controlOp1_in(controlOp1_in),
    .funct3_alu_in(funct3_alu_in), .Type_alu_in(Type_alu_in), .Type_dm_in(Type_dm_in),
    .BrOp_in(BrOp_in), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_stall(mem_stall),
    .alu_q(alu_q), .store_data_q(store_data_q), .pc4_q(pc4_q), .rd_q(rd_q),
    .we_q(we_q), .store_q(store_q), .load_q(load_q), .controlRF_q(controlRF_q),
    .Type_dm_q(Type_dm_q), .NextPCSrc(NextPCSrc), .branch_target(branch_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    sum_out_in = '0; pc_out_in = '0; data1_in = '0; data2_in = '0; imm_in = '0;
    rs1_in = '0; rs2_in = '0; rd_in = '0; we_in = 1'b0; store_in = 1'b0; load_in = 1'b0;
    controlRF_in = '0; controlALU_in = 1'b0; controlOp1_in = 1'b0; funct3_alu_in = '0;
    Type_alu_in = 1'b0; Type_dm_in = '0; BrOp_in = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; mem_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // b goes to imm when is_imm, else to data2 via rs2=11; rs1=10 is never a live rd here.
  task automatic alu_vec(input string tag, input logic [2:0] f3, input logic ty, input logic is_imm,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    clr();
    rs1_in = 5'd10; rs2_in = 5'd11; rd_in = 5'd12;
    data1_in = a; funct3_alu_in = f3; Type_alu_in = ty; controlALU_in = is_imm;
    if (is_imm) imm_in = b; else data2_in = b;
    tick();
    check(tag, alu_q, exp);
  endtask

  task automatic br_vec(input string tag, input logic [4:0] brop, input logic [31:0] a,
                        input logic [31:0] b, input logic exp_taken);
    clr();
    rs1_in = 5'd10; rs2_in = 5'd11; data1_in = a; data2_in = b;
    pc_out_in = 32'h100; imm_in = 32'h8; controlOp1_in = 1'b1; controlALU_in = 1'b1;
    BrOp_in = brop;
    #1;
    check({tag, "_taken"}, 32'(NextPCSrc), 32'(exp_taken));
    check({tag, "_tgt"}, branch_target, 32'h108);
    tick();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #2 rst = 1'b0;
    BrOp_in = 5'b10000;
    #1;
    check("rst_pc4", pc4_q, RST_PC);
    check("rst_npc", 32'(NextPCSrc), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    clr();

    // ADDI x5, x0, 0x10
    rd_in = 5'd5; we_in = 1'b1; controlALU_in = 1'b1; imm_in = 32'h10; sum_out_in = 32'h44;
    tick();
    check("addi_alu", alu_q, 32'h10);
    check("addi_pc4", pc4_q, 32'h44);
    check("addi_rd", 32'(rd_q), 32'd5);
    check("addi_we", 32'(we_q), 32'h1);

    // asynchronous reset mid-run, checked before any clock edge
    BrOp_in = 5'b10000;
    #2 rst = 1'b0;
    #1;
    check("mrst_alu", alu_q, 32'h0);
    check("mrst_pc4", pc4_q, RST_PC);
    check("mrst_rd", 32'(rd_q), 32'h0);
    check("mrst_we", 32'(we_q), 32'h0);
    check("mrst_npc", 32'(NextPCSrc), 32'h0);
    #1 rst = 1'b1;
    clr();

    // forwarding: EX/MEM beats MEM/WB
    rd_in = 5'd5; we_in = 1'b1; controlALU_in = 1'b1; imm_in = 32'h10;
    tick();
    clr();
    rs1_in = 5'd5; data1_in = 32'hDEAD; data2_in = 32'hBEEF;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h99; rd_in = 5'd6; we_in = 1'b1;
    tick();
    check("fwd_exmem", alu_q, 32'h10);
    check("st_x0", store_data_q, 32'h0);

    clr();
    rd_in = 5'd5; store_in = 1'b1;
    tick();
    check("store_q", 32'(store_q), 32'h1);
    clr();
    rs1_in = 5'd5; data1_in = 32'hDEAD;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h99; rd_in = 5'd6; we_in = 1'b1;
    tick();
    check("fwd_wb", alu_q, 32'h99);

    clr();
    data1_in = 32'h55; data2_in = 32'h66; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h77;
    tick();
    check("fwd_x0", alu_q, 32'h0);

    // a load in EX/MEM is not a forwarding source
    clr();
    rd_in = 5'd8; we_in = 1'b1; load_in = 1'b1; controlRF_in = 2'b01;
    controlALU_in = 1'b1; imm_in = 32'h40;
    tick();
    clr();
    rs1_in = 5'd8; data1_in = 32'h123; rd_in = 5'd9;
    tick();
    check("no_ld_fwd", alu_q, 32'h123);

    alu_vec("sub",   3'b000, 1'b1, 1'b0, 32'h0,         32'h1,         32'hFFFF_FFFF);
    alu_vec("srai",  3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF);
    alu_vec("srli",  3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'd31,        32'h1);
    alu_vec("slt",   3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h1);
    alu_vec("sltu",  3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0);
    alu_vec("addi",  3'b000, 1'b1, 1'b1, 32'h5,         32'h3,         32'h8);
    alu_vec("sll",   3'b001, 1'b0, 1'b0, 32'h1,         32'h24,        32'h10);
    alu_vec("xor",   3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu_vec("or",    3'b110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    alu_vec("and",   3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);

    br_vec("beq",   5'b01000, 32'h7,         32'h7,         1'b1);
    br_vec("bne",   5'b01001, 32'h7,         32'h7,         1'b0);
    br_vec("blt",   5'b01100, 32'hFFFF_FFFF, 32'h1,         1'b1);
    br_vec("bltu",  5'b01110, 32'hFFFF_FFFF, 32'h1,         1'b0);
    br_vec("bge",   5'b01101, 32'h1,         32'hFFFF_FFFF, 1'b1);
    br_vec("bgeu",  5'b01111, 32'h1,         32'hFFFF_FFFF, 1'b0);
    br_vec("br010", 5'b01010, 32'h7,         32'h7,         1'b0);
    br_vec("nobr",  5'b00000, 32'h7,         32'h7,         1'b0);

    // JALR x1, 0(x10) with x10 = 0x203
    clr();
    rs1_in = 5'd10; data1_in = 32'h203; controlALU_in = 1'b1; BrOp_in = 5'b10000;
    controlRF_in = 2'b10; rd_in = 5'd1; we_in = 1'b1; sum_out_in = 32'h208;
    #1;
    check("jalr_npc", 32'(NextPCSrc), 32'h1);
    check("jalr_tgt", branch_target, 32'h202);
    tick();
    check("jalr_crf", 32'(controlRF_q), 32'h2);
    check("jalr_pc4", pc4_q, 32'h208);
    clr();
    rs1_in = 5'd1; data1_in = 32'hBAD;
    tick();
    check("fwd_pc4", alu_q, 32'h208);

    // stall holds EX/MEM while inputs change
    clr();
    controlALU_in = 1'b1; imm_in = 32'h11; rd_in = 5'd3; we_in = 1'b1;
    sum_out_in = 32'h300; Type_dm_in = 3'b101;
    tick();
    check("pre_stall", alu_q, 32'h11);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imm_in = 32'h20 + 32'(i); rd_in = 5'd4; sum_out_in = 32'h400; we_in = 1'b0; Type_dm_in = 3'b010;
      tick();
      check("stall_alu", alu_q, 32'h11);
      check("stall_rd", 32'(rd_q), 32'd3);
      check("stall_pc4", pc4_q, 32'h300);
      check("stall_we", 32'(we_q), 32'h1);
      check("stall_tdm", 32'(Type_dm_q), 32'h5);
    end
    BrOp_in = 5'b10000;
    #1;
    check("stall_npc", 32'(NextPCSrc), 32'h1);
    BrOp_in = 5'b00000;
    imm_in = 32'h55;
    mem_stall = 1'b0;
    tick();
    check("rel_alu", alu_q, 32'h55);
    check("rel_rd", 32'(rd_q), 32'd4);
    check("rel_pc4", pc4_q, 32'h400);
    check("rel_we", 32'(we_q), 32'h0);

    // reset pulse released while stalled: stays at reset values until unstalled
    mem_stall = 1'b1;
    imm_in = 32'h66;
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    check("rstall_alu", alu_q, 32'h0);
    check("rstall_pc4", pc4_q, RST_PC);
    mem_stall = 1'b0;
    tick();
    check("rstall_rel", alu_q, 32'h66);

    // bubble after a we/store/load instruction
    clr();
    we_in = 1'b1; store_in = 1'b1; load_in = 1'b1; rd_in = 5'd20;
    tick();
    clr();
    data1_in = 32'hCAFE_F00D; data2_in = 32'h1234_5678; imm_in = 32'h7777; pc_out_in = 32'h5554;
    sum_out_in = 32'h5558; rs1_in = 5'd9; rs2_in = 5'd17; rd_in = 5'd31;
    #1;
    check("bub_npc", 32'(NextPCSrc), 32'h0);
    tick();
    check("bub_we", 32'(we_q), 32'h0);
    check("bub_st", 32'(store_q), 32'h0);
    check("bub_ld", 32'(load_q), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
